// File: rtl/lsu_pkg.sv
// Shared load/store-unit definitions.
//   - Size codes (funct3) carried with every memory request.
//   - sb_entry_t: one buffered store, kept verbatim as {addr, wdata, mask}.
//   - LSU_AW / LSU_DW: widths of the entry fields; the store buffer's AW/DW
//     parameters must match them.
package lsu_pkg;

  localparam int LSU_AW = 32;
  localparam int LSU_DW = 32;

  localparam logic [2:0] MASK_B  = 3'b000;
  localparam logic [2:0] MASK_H  = 3'b001;
  localparam logic [2:0] MASK_W  = 3'b010;
  localparam logic [2:0] MASK_BU = 3'b100;
  localparam logic [2:0] MASK_HU = 3'b101;

  typedef struct packed {
    logic [LSU_AW-1:0] addr;
    logic [LSU_DW-1:0] wdata;
    logic [2:0]        mask;
  } sb_entry_t;

endpackage

// File: rtl/sb_fifo.sv
// Circular buffer of sb_entry_t with a parallel word-address compare.
// Ports:
//   clk, rst     clock, asynchronous active-high reset (empties the buffer)
//   push         write push_entry at tail (caller guarantees count < DEPTH)
//   pop          retire the head entry (caller guarantees count > 0)
//   cmp_addr     byte address compared against every valid entry
//   head_entry   oldest entry
//   count        number of valid entries
//   hit          some valid entry holds the same 32-bit word as cmp_addr
module sb_fifo
  import lsu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  sb_entry_t                push_entry,
  input  logic                     pop,
  input  logic [LSU_AW-1:0]        cmp_addr,
  output sb_entry_t                head_entry,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     hit
);

  localparam int PW = $clog2(DEPTH);

  sb_entry_t         entries_q [DEPTH];
  sb_entry_t         entries_d [DEPTH];
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [PW:0]       count_q, count_d;

  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    if (push) begin
      entries_d[tail_q] = push_entry;
      tail_d            = tail_q + PW'(1);
    end
    if (pop) begin
      head_d = head_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entries_q <= '{default: '0};
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

  // Slot i is valid when its distance from head (modulo DEPTH) is below
  // count; pointers alone cannot tell full from empty.
  always_comb begin
    logic [PW-1:0] offset;
    offset = '0;
    hit    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      offset = PW'(i) - head_q;
      if (({1'b0, offset} < count_q) &&
          (entries_q[i].addr[LSU_AW-1:2] == cmp_addr[LSU_AW-1:2])) begin
        hit = 1'b1;
      end
    end
  end

  assign head_entry = entries_q[head_q];
  assign count      = count_q;

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer between the core LSU and data memory.
// Stores are accepted in one cycle and drained in FIFO order whenever the
// memory port is not taken by a load. Loads that miss the buffer go straight
// to memory; loads that hit a buffered word stall until the buffer no longer
// holds that word, so a load never sees memory older than a buffered store.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   core_*          request from the core (addr, wdata, mask, wr_en, rd_en)
//   flush           fence: stall until every buffered store has drained
//   core_rdata      load data (mem_rdata passed through)
//   stall           core must hold PC and request stable this cycle
//   empty, count    buffer occupancy (registered)
//   mem_*           single read/write port to data memory
//
// Handshake: a request (core_wr_en or core_rd_en) is taken in the cycle
// where it is asserted with stall=0; while stall=1 the core keeps the same
// request on the bus and nothing about it is committed, except a store that
// arrives together with flush, which is pushed whenever a slot is free.
module store_buffer
  import lsu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = LSU_AW,
  parameter int DW    = LSU_DW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [AW-1:0]          core_addr,
  input  logic [DW-1:0]          core_wdata,
  input  logic [2:0]             core_mask,
  input  logic                   core_wr_en,
  input  logic                   core_rd_en,
  input  logic                   flush,
  output logic [DW-1:0]          core_rdata,
  output logic                   stall,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [AW-1:0]          mem_addr,
  output logic [DW-1:0]          mem_wdata,
  output logic [2:0]             mem_mask,
  output logic                   mem_wr_en,
  output logic                   mem_rd_en,
  input  logic [DW-1:0]          mem_rdata
);

  localparam int CW = $clog2(DEPTH) + 1;

  sb_entry_t     push_entry;
  sb_entry_t     head_entry;
  logic [CW-1:0] fifo_count;
  logic          hit;
  logic          full;
  logic          has_entries;
  logic          load_only;
  logic          rd_port;
  logic          push;

  assign push_entry = '{addr: core_addr, wdata: core_wdata, mask: core_mask};

  sb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (mem_wr_en),
    .cmp_addr   (core_addr),
    .head_entry (head_entry),
    .count      (fifo_count),
    .hit        (hit)
  );

  always_comb begin
    full        = (fifo_count == CW'(DEPTH));
    has_entries = (fifo_count != '0);
    load_only   = core_rd_en & ~core_wr_en;
    // A missing read request owns the memory port even when it rides along
    // with a store (its data is then ignored): drain waits for a cycle with
    // no read traffic.
    rd_port     = core_rd_en & ~hit & ~rst;
    // A full buffer refuses the store even if a drain frees a slot this
    // cycle; the held store is taken next cycle.
    push        = core_wr_en & ~full;
    stall       = ~rst & ((core_wr_en & full) |
                          (load_only & hit) |
                          (flush & has_entries));

    mem_addr  = '0;
    mem_wdata = '0;
    mem_mask  = '0;
    mem_wr_en = 1'b0;
    mem_rd_en = 1'b0;
    if (rd_port) begin
      mem_addr  = core_addr;
      mem_mask  = core_mask;
      mem_rd_en = 1'b1;
    end else if (has_entries) begin
      mem_addr  = head_entry.addr;
      mem_wdata = head_entry.wdata;
      mem_mask  = head_entry.mask;
      mem_wr_en = 1'b1;
    end
  end

  assign core_rdata = mem_rdata;
  assign count      = fifo_count;
  assign empty      = ~has_entries;

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;
  import lsu_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   core_addr, core_wdata, core_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [2:0]    core_mask, mem_mask;
  logic          core_wr_en, core_rd_en, flush, stall, empty, mem_wr_en, mem_rd_en;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_mask(core_mask),
    .core_wr_en(core_wr_en), .core_rd_en(core_rd_en), .flush(flush),
    .core_rdata(core_rdata), .stall(stall), .empty(empty), .count(count),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_mask(mem_mask),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata)
  );

  // ---------------- counters / scoreboard ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  int          accepted_stores = 0;
  int          writes_seen = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ref_mem [256];   // architectural memory: every accepted store applied in order
  logic [31:0] mem_arr [256];   // the data memory the DUT talks to

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Byte/half/word lane placement as little-endian memory does it.
  function automatic logic [31:0] apply_store(input logic [31:0] old, input logic [31:0] a,
                                              input logic [31:0] d, input logic [2:0] m);
    logic [31:0] w;
    w = old;
    if (m == MASK_B || m == MASK_BU) w[8*a[1:0] +: 8] = d[7:0];
    else if (m == MASK_H || m == MASK_HU) w[16*a[1] +: 16] = d[15:0];
    else w = d;
    return w;
  endfunction

  // ---------------- data memory: combinational read, negedge commit ----------------
  assign mem_rdata = mem_arr[mem_addr[9:2]];

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem_arr[i] = '0;
    end else if (mem_wr_en) begin
      mem_arr[mem_addr[9:2]] = apply_store(mem_arr[mem_addr[9:2]], mem_addr, mem_wdata, mem_mask);
      writes_seen++;
    end
  end

  // ---------------- monitor: every granted load is checked against the queue ----------------
  always @(negedge clk) begin
    if (!rst && core_rd_en && !core_wr_en && !stall) begin
      check("grant_mem_rd_en", {mem_rd_en, mem_wr_en}, 2'b10);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL load_data: grant with no expected load, got 0x%0h", core_rdata);
      end else begin
        check("load_data", core_rdata, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] m,
                          input bit with_rd, output int stalls);
    core_addr = a; core_wdata = d; core_mask = m;
    core_wr_en = 1'b1; core_rd_en = with_rd; stalls = 0;
    @(negedge clk);
    while (stall && stalls < 50) begin
      stalls++;
      @(posedge clk); #1;
      core_rd_en = 1'b0;   // read traffic stops so the buffer can drain
      @(negedge clk);
    end
    if (stall) fail_now("store_accept");
    else begin
      ref_mem[a[9:2]] = apply_store(ref_mem[a[9:2]], a, d, m);
      accepted_stores++;
    end
    @(posedge clk); #1;
    core_wr_en = 1'b0; core_rd_en = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [2:0] m,
                         output int stalls, output logic [31:0] rdata);
    exp_q.push_back(ref_mem[a[9:2]]);
    core_addr = a; core_mask = m; core_wr_en = 1'b0; core_rd_en = 1'b1; stalls = 0;
    @(negedge clk);
    while (stall && stalls < 50) begin
      stalls++;
      @(posedge clk); #1;
      @(negedge clk);
    end
    if (stall) fail_now("load_grant");
    rdata = core_rdata;
    @(posedge clk); #1;
    core_rd_en = 1'b0;
  endtask

  task automatic do_flush(output int stalls);
    flush = 1'b1; stalls = 0;
    @(negedge clk);
    while (stall && stalls < 50) begin
      stalls++;
      @(posedge clk); #1;
      @(negedge clk);
    end
    if (stall) fail_now("flush_release");
    check("flush_empty", empty, 1'b1);
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int          s;
    int          ws;
    logic [31:0] rd;
    logic [2:0]  masks [5];
    masks = '{MASK_B, MASK_H, MASK_W, MASK_BU, MASK_HU};
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    rst = 1'b1;
    core_addr = '0; core_wdata = '0; core_mask = '0;
    core_wr_en = 1'b0; core_rd_en = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", stall, 1'b0);
    check("rst_empty", empty, 1'b1);
    check("rst_count", count, '0);
    check("rst_mem_en", {mem_wr_en, mem_rd_en}, 2'b00);
    check("rst_mem_bus", {mem_addr, mem_wdata, mem_mask}, '0);
    rst = 1'b0;
    idle(1);

    // store then drain
    do_store(32'h10, 32'hDEADBEEF, MASK_W, 1'b0, s);
    check("sd_stall", s, 0);
    check("sd_count1", count, 1);
    @(negedge clk);
    check("sd_wr_en", mem_wr_en, 1'b1);
    check("sd_addr", mem_addr, 32'h10);
    check("sd_wdata", mem_wdata, 32'hDEADBEEF);
    @(posedge clk); #1;
    check("sd_count0", count, 0);
    check("sd_empty", empty, 1'b1);

    // load miss takes the port ahead of a buffered store
    do_store(32'h40, 32'h11223344, MASK_W, 1'b0, s);
    check("miss_count_before", count, 1);
    exp_q.push_back(ref_mem[32'h80 >> 2]);
    core_addr = 32'h80; core_mask = MASK_W; core_rd_en = 1'b1;
    @(negedge clk);
    check("miss_ports", {mem_rd_en, mem_wr_en, stall}, 3'b100);
    @(posedge clk); #1;
    core_rd_en = 1'b0;
    check("miss_count_held", count, 1);
    @(negedge clk);
    check("miss_drain", {mem_wr_en, mem_addr}, {1'b1, 32'h40});
    @(posedge clk); #1;
    check("miss_count_after", count, 0);

    // load hitting a buffered byte waits for it to drain
    do_store(32'h21, 32'h000000AB, MASK_B, 1'b0, s);
    do_load(32'h20, MASK_W, s, rd);
    check("hit_stall_cycles", s, 1);
    check("hit_byte1", rd[15:8], 8'hAB);
    idle(2);

    // fill to full with read traffic blocking drain, then flush
    for (int i = 0; i < 5; i++) begin
      if (i == 4) check("fill_count_full", count, DEPTH);
      do_store(32'h300 + 32'(4 * i), $urandom, MASK_W, 1'b1, s);
      check("fill_stall_cycles", s, (i == 4) ? 2 : 0);
    end
    check("fill_count_after", count, 3);
    do_flush(s);
    check("flush_stall_cycles", s, 3);

    // randomized traffic over a small window so hits are frequent
    for (int it = 0; it < 400; it++) begin
      int          r;
      logic [31:0] a;
      logic [2:0]  m;
      r = $urandom_range(0, 9);
      m = masks[$urandom_range(0, 4)];
      a = 32'h100 + 32'($urandom_range(0, 7) * 4);
      if (m == MASK_B || m == MASK_BU) a = a + 32'($urandom_range(0, 3));
      else if (m == MASK_H || m == MASK_HU) a = a + 32'($urandom_range(0, 1) * 2);
      if (r <= 3) do_store(a, $urandom, m, 1'($urandom_range(0, 1)), s);
      else if (r <= 6) do_load(a, MASK_W, s, rd);
      else if (r <= 8) idle(1);
      else do_flush(s);
    end
    do_flush(s);
    idle(1);
    check("exp_q_drained", exp_q.size(), 0);
    check("write_count", writes_seen, accepted_stores);
    for (int i = 0; i < 256; i++) begin
      if (mem_arr[i] !== ref_mem[i]) check($sformatf("mem_word_%0d", i), mem_arr[i], ref_mem[i]);
      else n_tests++;
    end

    // asynchronous reset in the middle of buffered work
    for (int i = 0; i < 3; i++) do_store(32'h380 + 32'(4 * i), $urandom, MASK_W, 1'b1, s);
    check("mid_count3", count, 3);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_count", count, 0);
    check("mid_rst_empty", empty, 1'b1);
    check("mid_rst_wr_en", mem_wr_en, 1'b0);
    check("mid_rst_stall", stall, 1'b0);
    ws = writes_seen;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(5);
    check("mid_no_writes", writes_seen, ws);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer between the core's load/store datapath and the data memory.
- Accepts stores in one cycle and queues them in a FIFO.
- Drains queued stores to memory on cycles without a load; loads are serviced directly.
- Stalls the core on buffer-full, on a load hitting a buffered word, and on flush until empty.

Parameters:
DEPTH, 4, number of buffered stores; power of two, 2..16
AW, 32, address width in bits
DW, 32, data width in bits

Ports:
clk  in  1  system clock; FIFO state updates on posedge
rst  in  1  asynchronous, active-high reset
core_addr  in  AW  byte address from core
core_wdata  in  DW  store data from core
core_mask  in  3  funct3 size code: 000 byte, 001 half, 010 word, 100 byte-u, 101 half-u
core_wr_en  in  1  store request
core_rd_en  in  1  load request
flush  in  1  fence: drain all entries before proceeding
core_rdata  out  DW  load data returned to core; equals mem_rdata
stall  out  1  core must hold PC and request stable this cycle
empty  out  1  no buffered stores
count  out  $clog2(DEPTH)+1  number of valid entries
mem_addr  out  AW  address to data memory
mem_wdata  out  DW  store data to data memory
mem_mask  out  3  size code to data memory
mem_wr_en  out  1  memory write enable; memory commits on negedge clk
mem_rd_en  out  1  memory read enable
mem_rdata  in  DW  combinational read data from memory

Behaviour:
- Reset (async, rst=1):
  - head, tail and count go to 0; all entries are discarded.
  - Outputs: stall=0, empty=1, mem_wr_en=0, mem_rd_en=0; mem_addr, mem_wdata and mem_mask are 0.
  - Stores pending when reset asserts are lost; this is not an error.
- Entry contents: {addr, wdata, mask}, stored verbatim with no realignment. Byte and half placement is left to the memory.
- Word-hit definition: a load hits if any valid entry has entry.addr[AW-1:2] == core_addr[AW-1:2], regardless of mask.
- Port arbitration (combinational, per cycle, in priority order):
  1. Load with no hit: drive mem_addr=core_addr, mem_mask=core_mask, mem_rd_en=1, mem_wr_en=0. No drain this cycle. stall=0.
  2. Load that hits: stall=1. Drive the head entry on the mem port with mem_wr_en=1, mem_rd_en=0.
  3. Otherwise, if count>0: drive the head entry, mem_wr_en=1, mem_rd_en=0.
  4. Otherwise: all mem_* outputs are 0.
- Posedge updates:
  - Pop: if mem_wr_en=1, the head advances and count decrements. Memory has already committed at the preceding negedge.
  - Push: if core_wr_en=1 and count<DEPTH, write the entry at tail, tail advances, count increments.
  - Push and pop in the same cycle leave count unchanged.
- Full: core_wr_en=1 with count==DEPTH gives stall=1 and no push, even if a pop occurs in the same cycle. The store is accepted on the next cycle.
- Flush: flush=1 with count>0 gives stall=1. stall drops combinationally in the cycle count==0.
- A store issued in the same cycle as flush is pushed only when count<DEPTH. Flush then keeps stalling until that store has also drained.
- Simultaneous core_wr_en and core_rd_en: treated as a store only; the load is ignored.
- Ordering: stores drain strictly FIFO. A load never observes memory older than a buffered store to the same word.
- Pointer wrap: head and tail are log2(DEPTH) bits and wrap modulo DEPTH. count distinguishes full from empty.
- core_rdata = mem_rdata, passed through combinationally, valid only when the load is granted (stall=0).
- No output is registered other than count and empty; latency for an accepted store is 0 stall cycles.

Decomposition:
- Shared package (lsu_pkg) holds:
  - the mask encoding constants MASK_B, MASK_H, MASK_W, MASK_BU, MASK_HU;
  - the sb_entry_t struct {addr, wdata, mask}.
- One sub-module, sb_fifo: a parameterised circular buffer with push/pop, head output, count, and a parallel word-address compare returning hit.
- store_buffer itself holds the arbitration and stall logic.

Test Plan:
- Store then drain: sw 0xDEADBEEF to 0x10, no loads. Expect:
  - count=1 after the posedge;
  - next cycle mem_wr_en=1, mem_addr=0x10;
  - count=0 and empty=1 after that cycle.
- Fill to full (DEPTH=4): five back-to-back stores while a load to 0x200 is held every cycle, blocking drain. Expect:
  - stall=1 on the fifth store;
  - once loads stop, a drain frees a slot and the fifth store is pushed on the following cycle.
- Load hit: sb 0xAB to 0x21, then lw 0x20 the next cycle. Expect:
  - stall=1 for one cycle while the entry drains;
  - then the load is granted with mem_rd_en=1 and returns the word with byte1=0xAB.
- Load miss priority: one entry buffered at 0x40, lw 0x80. Expect:
  - mem_rd_en=1, mem_wr_en=0, stall=0;
  - count stays 1, and the entry drains next idle cycle.
- Flush: three stores buffered, flush=1. Expect stall=1 for exactly three cycles, then stall=0 and empty=1.
- Async reset mid-operation: count=3, assert rst between clock edges. Expect count=0, empty=1 and mem_wr_en=0 immediately, and no further writes after release.
